// File: rtl/qdec_pkg.sv
// Shared types, defaults and the quadrature step decoder for quad_decoder_array.
package qdec_pkg;

  localparam int unsigned DEF_CHANNELS    = 2;
  localparam int unsigned DEF_POS_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_LEN    = 3;
  localparam int unsigned DEF_VEL_W       = 12;
  localparam int unsigned DEF_VEL_PERIOD  = 50000;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ILLEGAL
  } step_e;

  // States are {B,A}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic step_e decode(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    s = STEP_NONE;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_INC;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: s = STEP_DEC;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ILLEGAL;
      default:                                s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_decoder_array_channel.sv
// One encoder channel: synchronizer, glitch filter, decode, position, sticky err,
// and (with QDEC_VELOCITY_EN) a saturating per-window step accumulator.
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int unsigned POS_W       = DEF_POS_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter int unsigned VEL_W       = DEF_VEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             load,
  input  logic [POS_W-1:0] load_val,
  input  logic             clr_err,
`ifdef QDEC_VELOCITY_EN
  input  logic             win_last,
`endif
  output logic [POS_W-1:0] position,
  output logic             err,
  output logic [VEL_W-1:0] velocity
);

  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] synced;
  logic [1:0] cur;
  logic [1:0] prev;
  step_e      step;

  always_ff @(posedge clk) begin
    sync_q[0] <= {in_b, in_a};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (FILT_LEN == 0) begin : g_nofilt
    assign cur = synced;
  end else begin : g_filt
    localparam int unsigned CW = $clog2(FILT_LEN + 1);
    logic [1:0]    last;
    logic [1:0]    filt;
    logic [CW-1:0] run;
    logic [CW-1:0] held;

    // held = consecutive cycles, including this one, that synced has kept its value
    always_comb begin
      held = CW'(1);
      if (synced == last) begin
        held = (run >= CW'(FILT_LEN)) ? CW'(FILT_LEN) : run + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      last <= synced;
      run  <= held;
      if (held >= CW'(FILT_LEN)) begin
        filt <= synced;
      end
    end

    assign cur = filt;
  end

  assign step = decode(prev, cur);

  always_ff @(posedge clk) begin
    prev <= cur;
    if (rst) begin
      position <= '0;
      err      <= 1'b0;
    end else begin
      if (load) begin
        position <= load_val;
      end else if (step == STEP_INC) begin
        position <= position + POS_W'(1);
      end else if (step == STEP_DEC) begin
        position <= position - POS_W'(1);
      end
      if (step == STEP_ILLEGAL) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

`ifdef QDEC_VELOCITY_EN
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VMIN = -VMAX;
  logic signed [VEL_W-1:0] acc;
  logic signed [VEL_W-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (step == STEP_INC && acc != VMAX) begin
      acc_next = acc + VEL_W'(1);
    end else if (step == STEP_DEC && acc != VMIN) begin
      acc_next = acc - VEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      velocity <= '0;
    end else if (win_last) begin
      velocity <= acc_next;
      acc      <= '0;
    end else begin
      acc <= acc_next;
    end
  end
`else
  assign velocity = '0;
`endif

endmodule

// File: rtl/quad_decoder_array.sv
// Multi-channel 4x quadrature decoder. Define QDEC_VELOCITY_EN to build the
// shared velocity window and per-channel velocity outputs.
module quad_decoder_array
  import qdec_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEF_CHANNELS,
  parameter int unsigned POS_W       = DEF_POS_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter int unsigned VEL_W       = DEF_VEL_W,
  parameter int unsigned VEL_PERIOD  = DEF_VEL_PERIOD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_a,
  input  logic [CHANNELS-1:0]       in_b,
  input  logic [CHANNELS-1:0]       load,
  input  logic [POS_W-1:0]          load_val,
  input  logic                      clr_err,
  output logic [CHANNELS*POS_W-1:0] position,
  output logic [CHANNELS-1:0]       err,
  output logic [CHANNELS*VEL_W-1:0] velocity,
  output logic                      vel_valid
);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("quad_decoder_array: CHANNELS must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("quad_decoder_array: SYNC_STAGES must be >= 2");
  end
  if (VEL_PERIOD < 2) begin : g_bad_period
    $error("quad_decoder_array: VEL_PERIOD must be >= 2");
  end

`ifdef QDEC_VELOCITY_EN
  localparam int unsigned CNT_W = $clog2(VEL_PERIOD);
  logic [CNT_W-1:0] win_cnt;
  logic             win_last;

  assign win_last = (win_cnt == CNT_W'(VEL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= win_last;
      win_cnt   <= win_last ? '0 : win_cnt + CNT_W'(1);
    end
  end
`else
  assign vel_valid = 1'b0;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    qdec_channel #(
      .POS_W      (POS_W),
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .VEL_W      (VEL_W)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .in_a    (in_a[n]),
      .in_b    (in_b[n]),
      .load    (load[n]),
      .load_val(load_val),
      .clr_err (clr_err),
`ifdef QDEC_VELOCITY_EN
      .win_last(win_last),
`endif
      .position(position[n*POS_W +: POS_W]),
      .err     (err[n]),
      .velocity(velocity[n*VEL_W +: VEL_W])
    );
  end

endmodule

// File: tb/tb_quad_decoder_array.sv
// Self-checking bench for quad_decoder_array: constant vector table, directed
// corner sequences and a randomized run against a Gray-index reference model.
module tb_quad_decoder_array;

  localparam int unsigned CH = 2;
  localparam int unsigned PW = 16;
  localparam int unsigned VW = 12;
  localparam int unsigned VP = 100;

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b1;
  logic [CH-1:0]        in_a     = '0;
  logic [CH-1:0]        in_b     = '0;
  logic [CH-1:0]        load     = '0;
  logic [PW-1:0]        load_val = '0;
  logic                 clr_err  = 1'b0;
  logic [CH*PW-1:0]     position;
  logic [CH-1:0]        err;
  logic [CH*VW-1:0]     velocity;
  logic                 vel_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [1:0]    ba_m  [CH];
  logic [PW-1:0] pos_m [CH];
  logic          err_m [CH];

  typedef struct {
    logic [1:0]    ba;
    logic [PW-1:0] pos;
    logic          e;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  quad_decoder_array #(
    .CHANNELS   (CH),
    .POS_W      (PW),
    .SYNC_STAGES(2),
    .FILT_LEN   (3),
    .VEL_W      (VW),
    .VEL_PERIOD (VP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_a     (in_a),
    .in_b     (in_b),
    .load     (load),
    .load_val (load_val),
    .clr_err  (clr_err),
    .position (position),
    .err      (err),
    .velocity (velocity),
    .vel_valid(vel_valid)
  );

  // Position along the forward cycle 00,10,11,01.
  function automatic int gidx(input logic [1:0] ba);
    case (ba)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [PW-1:0] pos_of(input int ch);
    return position[ch*PW +: PW];
  endfunction

  function automatic logic [VW-1:0] vel_of(input int ch);
    return velocity[ch*VW +: VW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ba(input int ch, input logic [1:0] ba);
    int d;
    d = (gidx(ba) - gidx(ba_m[ch]) + 4) % 4;
    if (d == 1) pos_m[ch] = pos_m[ch] + PW'(1);
    else if (d == 3) pos_m[ch] = pos_m[ch] - PW'(1);
    else if (d == 2) err_m[ch] = 1'b1;
    ba_m[ch] = ba;
    in_b[ch] = ba[1];
    in_a[ch] = ba[0];
  endtask

  task automatic step(input int ch, input int dir);
    set_ba(ch, gval(gidx(ba_m[ch]) + dir + 4));
  endtask

  task automatic do_load(input logic [CH-1:0] mask, input logic [PW-1:0] val);
    load_val = val;
    load     = mask;
    for (int c = 0; c < CH; c++) if (mask[c]) pos_m[c] = val;
    tick(1);
    load = '0;
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    for (int c = 0; c < CH; c++) err_m[c] = 1'b0;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < CH; c++) begin
      check({tag, "_pos"}, pos_of(c), pos_m[c]);
      check({tag, "_err"}, err[c], err_m[c]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    int pulses;
    int nonzero;
    logic [PW-1:0] rv;

    for (int c = 0; c < CH; c++) begin
      ba_m[c] = 2'b00; pos_m[c] = '0; err_m[c] = 1'b0;
    end
    tbl[0] = '{2'b10, 16'd1,      1'b0};
    tbl[1] = '{2'b11, 16'd2,      1'b0};
    tbl[2] = '{2'b01, 16'd3,      1'b0};
    tbl[3] = '{2'b00, 16'd4,      1'b0};
    tbl[4] = '{2'b01, 16'd3,      1'b0};
    tbl[5] = '{2'b11, 16'd2,      1'b0};
    tbl[6] = '{2'b10, 16'd1,      1'b0};
    tbl[7] = '{2'b00, 16'd0,      1'b0};
    tbl[8] = '{2'b01, 16'hFFFF,   1'b0};
    tbl[9] = '{2'b10, 16'hFFFF,   1'b1};

    tick(10);
    check("rst_pos0", pos_of(0), 0);
    check("rst_pos1", pos_of(1), 0);
    check("rst_err", err, 0);
    check("rst_vel", velocity, 0);
    check("rst_vvalid", vel_valid, 0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      set_ba(0, tbl[i].ba);
      tick(8);
      check("tbl_pos", pos_of(0), tbl[i].pos);
      check("tbl_err", err[0], tbl[i].e);
      check("tbl_ch1", pos_of(1), 0);
    end
    do_clr();
    check("clr_err", err[0], 0);

    // full forward cycle with exact latency on the last edge
    do_load(2'b01, 16'd0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1);
      tick(8);
    end
    step(0, 1);
    tick(5);
    check("fwd_early", pos_of(0), 3);
    tick(1);
    check("fwd_pos", pos_of(0), 4);
    check("fwd_ch1", pos_of(1), 0);

    do_load(2'b01, 16'h7FFF);
    check("load_lat", pos_of(0), 16'h7FFF);
    step(0, 1);
    tick(8);
    check("wrap_up", pos_of(0), 16'h8000);
    step(0, -1);
    tick(8);
    check("wrap_down", pos_of(0), 16'h7FFF);

    in_a[0] = ~in_a[0];
    tick(2);
    in_a[0] = ~in_a[0];
    tick(10);
    check("glitch_pos", pos_of(0), 16'h7FFF);
    check("glitch_err", err[0], 0);

    set_ba(0, ba_m[0] ^ 2'b11);
    tick(8);
    check("illegal_err", err[0], 1);
    check("illegal_pos", pos_of(0), 16'h7FFF);
    set_ba(0, ba_m[0] ^ 2'b11);
    tick(5);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_vs_illegal", err[0], 1);
    do_clr();
    check("clr_after", err[0], 0);

    step(0, 1);
    tick(5);
    load_val = 16'h1234;
    load     = 2'b01;
    tick(1);
    load     = '0;
    pos_m[0] = 16'h1234;
    check("load_vs_cnt", pos_of(0), 16'h1234);
    tick(4);
    check("load_vs_cnt_hold", pos_of(0), 16'h1234);
    check_model("directed");

    for (int it = 0; it < 150; it++) begin
      for (int c = 0; c < CH; c++) begin
        int r;
        r = $urandom_range(0, 7);
        if (r <= 2) step(c, 1);
        else if (r <= 5) step(c, -1);
        else if (r == 6) set_ba(c, ba_m[c] ^ 2'b11);
      end
      tick(8);
      check_model("rnd");
      if ($urandom_range(0, 3) == 0) begin
        rv = PW'($urandom);
        do_load(CH'($urandom_range(1, 3)), rv);
        check_model("rnd_load");
      end
      if ($urandom_range(0, 4) == 0) begin
        do_clr();
        check_model("rnd_clr");
      end
    end

    // reset mid-rotation with inputs at 11
    rst  = 1'b1;
    in_a = '1;
    in_b = '1;
    for (int c = 0; c < CH; c++) begin
      ba_m[c] = 2'b11; pos_m[c] = '0; err_m[c] = 1'b0;
    end
    tick(10);
    check("rst11_pos", pos_of(0), 0);
    rst = 1'b0;
    tick(12);
    check_model("rst11");

    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1);
      for (int j = 0; j < 7; j++) begin
        tick(1);
        if (vel_valid) pulses++;
      end
    end
    check_model("vel_steps");
`ifdef QDEC_VELOCITY_EN
    check("vel_no_early", pulses, 0);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      tick(1);
      if (vel_valid) found = 1;
    end
    check("vel_pulse1", found, 1);
    check("vel_cycle1", cyc, VP);
    check("vel_ch0", vel_of(0), 10);
    check("vel_ch1", vel_of(1), 0);
    tick(1);
    check("vel_one_cycle", vel_valid, 0);
    check("vel_stable", vel_of(0), 10);
    found = 0;
    for (int i = 0; i < 120 && found == 0; i++) begin
      tick(1);
      if (vel_valid) found = 1;
    end
    check("vel_pulse2", found, 1);
    check("vel_cycle2", cyc, 2 * VP);
    check("vel_quiet", vel_of(0), 0);
`else
    nonzero = 0;
    for (int i = 0; i < 2 * VP; i++) begin
      tick(1);
      if (vel_valid) pulses++;
      if (velocity != '0) nonzero++;
    end
    check("novel_valid", pulses, 0);
    check("novel_velocity", nonzero, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder_array.md
# quad_decoder_array

Parametrised multi-channel 4x quadrature decoder, successor to the single-channel 16-bit decoder. It serves up to CHANNELS encoders from one clock. Each channel has a configurable synchronizer depth, a glitch filter, a preset load, sticky illegal-transition detection and an optional windowed velocity measurement. It sits between the encoder input pins and the register/SPI front end that reads positions.

## Interface
- CHANNELS, 2: number of encoder channels (1..8)
- POS_W, 16: signed position width per channel
- SYNC_STAGES, 2: synchronizer flops per input (>=2)
- FILT_LEN, 3: cycles an input must be stable before it is accepted; 0 bypasses the filter
- VEL_W, 12: signed velocity width per channel
- VEL_PERIOD, 50000: velocity window length in clk cycles (>=2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_a  in  CHANNELS  raw encoder A inputs (asynchronous)
- in_b  in  CHANNELS  raw encoder B inputs (asynchronous)
- load  in  CHANNELS  per-channel preset strobe
- load_val  in  POS_W  preset value, shared by all channels
- clr_err  in  1  clears all error flags
- position  out  CHANNELS*POS_W  signed positions; channel n occupies [n*POS_W +: POS_W]
- err  out  CHANNELS  sticky illegal-transition flags
- velocity  out  CHANNELS*VEL_W  signed counts per window, packed like position
- vel_valid  out  1  one-cycle pulse when velocity updates

## Operation
- Per channel, the pipeline is: synchronizer → filter → edge decode → position and velocity accumulators.
- Filter: the filtered {B,A} takes a new value only after the synchronized {B,A} has held that value for FILT_LEN consecutive cycles. A value that changes back earlier is discarded.
- Decode compares the previous filtered state `prev` with the current filtered state `cur`, both as {B,A}.
  - Forward sequence 00→10→11→01→00: position +1.
  - Reverse sequence: position −1.
  - No change: hold.
  - Both bits changed (00↔11, 01↔10): position holds and err[n] is set.
- `prev` updates to `cur` every cycle.
- Position arithmetic is POS_W two's complement and wraps: max+1 → min, min−1 → max.
- load[n] writes load_val to position[n]. Load wins over a simultaneous count, and the velocity accumulator still counts that step.
- err is sticky until clr_err. If clr_err coincides with a new error, the flag stays set.
- Velocity:
  - A shared window counter runs 0..VEL_PERIOD−1.
  - Each channel accumulates signed ±1 steps during the window, saturating at ±(2^(VEL_W−1)−1).
  - On the last window cycle, velocity[n] takes the accumulated total including that cycle's step, the accumulator clears, and vel_valid pulses.
- Reset values: position 0, err 0, velocity 0, vel_valid 0, window counter 0, accumulators 0.
- During rst, `prev` loads `cur`, so leaving reset mid-rotation produces no spurious count.
- Synchronizer and filter flops are not reset and keep sampling while rst is high.

## Timing
- Raw input edge to position change takes SYNC_STAGES + FILT_LEN + 1 cycles. With defaults this is 6; with FILT_LEN = 0 it is SYNC_STAGES + 1.
- A load strobe at edge k makes the new position visible after edge k, so the latency is 1.
- Illegal transition to err high: same latency as a count.
- vel_valid is high for exactly one cycle every VEL_PERIOD cycles. The first pulse comes VEL_PERIOD cycles after rst deasserts. velocity is stable between pulses.
- Maximum countable rate is one filtered state change per FILT_LEN+1 cycles. Faster input is filtered or flagged, never miscounted silently.

## Configuration
- QDEC_VELOCITY_EN defined: the window counter, accumulators, velocity and vel_valid are implemented as described.
- Not defined: velocity and vel_valid are tied to 0, no velocity logic is synthesized, and VEL_W and VEL_PERIOD are ignored.

## Structure
- Package qdec_pkg:
  - step enum {STEP_NONE, STEP_INC, STEP_DEC, STEP_ILLEGAL}
  - decode function mapping {prev, cur} to a step
  - default parameter constants
- Sub-module qdec_channel holds the synchronizer, filter, decode, position register, err flag and velocity accumulator for one channel.
- The top generates CHANNELS instances of qdec_channel and owns the shared window counter and vel_valid.

## Test plan
- Forward rotation: one full forward cycle of 4 transitions on ch0 from reset (defaults) → position[0] = 4 after the last edge + 6 cycles; ch1 stays 0.
- Wrap: load 16'h7FFF, then one forward step → 16'h8000. Reverse step from 16'h8000 → 16'h7FFF.
- Glitch and illegal transition:
  - A 2-cycle pulse on in_a (FILT_LEN = 3) → no count.
  - 00→11 held stable → err[0] = 1 and position unchanged.
  - clr_err in the same cycle as a second illegal transition → err stays 1.
- Load and reset:
  - load[0] in the same cycle as a decoded +1 → position[0] = load_val.
  - rst asserted with inputs at 11 → position 0 and no count after release.
- Velocity (VEL_PERIOD = 100): 10 forward steps within one window → vel_valid pulses at cycle 100 with velocity[0] = 10. The next quiet window → 0.
- Macro off: same stimulus → velocity = 0 and vel_valid = 0 throughout.
